// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one write FIFO among NUM_REQ burst-oriented requesters.
//   Round-robin arbitration happens at burst granularity: the granted requester
//   owns the FIFO write port until its beat flagged last is accepted. One IDLE
//   cycle is spent on every arbitration; no beat is accepted in IDLE.
//
// Optional feature (macro FIFO_ARB_BURST_LIMIT_EN):
//   defined   - bursts are capped at MAX_BURST beats; a capped burst releases the
//               grant like a last beat and pulses burst_trunc with that beat.
//   undefined - bursts are unbounded, burst_trunc is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_last     per-requester final beat of burst
//   req_data     per-requester beat data, requester i at [i*DATA_W +: DATA_W]
//   req_ready    per-requester accept (owner only, and only while FIFO not full)
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write enable
//   fifo_wr_data FIFO write data (combinational pass-through of owner data)
//   grant        registered one-hot owner, zero when idle
//   busy         high while a burst owns the FIFO
//   burst_trunc  one-cycle pulse when a grant is released by the beat limit
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      burst_trunc
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_busy;

  logic               w_found;
  logic [PTR_W-1:0]   w_pick;
  logic [PTR_W-1:0]   w_next;
  logic               w_accept;
  logic               w_last;
  logic               w_release;
  logic [DATA_W-1:0]  w_data;

  // r_grant is zero outside BURST, so ready/write are inherently gated by state.
  assign req_ready    = fifo_full ? '0 : r_grant;
  assign fifo_wr_en   = (|(req_valid & r_grant)) & ~fifo_full;
  assign fifo_wr_data = w_data;
  assign grant        = r_grant;
  assign busy         = r_busy;

  assign w_accept = fifo_wr_en;
  assign w_last   = req_last[r_owner];
  assign w_next   = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PTR_W'(i)) w_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // First valid requester at or above the RR pointer, wrapping.
  always_comb begin : arb_pick
    int unsigned k;
    k       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(r_ptr) + i) % NUM_REQ;
      if (!w_found && req_valid[k]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'(k);
      end
    end
  end

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_limit;

  // r_cnt holds beats already accepted, so the beat being accepted now is
  // number MAX_BURST when r_cnt equals MAX_BURST-1.
  assign w_limit     = (r_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release   = w_accept & (w_last | w_limit);
  assign burst_trunc = w_accept & ~w_last & w_limit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_release) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_release   = w_accept & w_last;
  assign burst_trunc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= BURST;
            r_grant <= NUM_REQ'(1) << w_pick;
            r_owner <= w_pick;
            r_busy  <= 1'b1;
          end
        end
        BURST: begin
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=128, MAX_BURST=16).
// Requesters are modelled as beat counters; per-cycle grant/write/trunc history
// is compared against hand-derived expected timelines, and every FIFO write is
// checked for in-order, gap-free data per requester.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;
  localparam int MB = 16;
  localparam int HN = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              burst_trunc;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy),
    .burst_trunc  (burst_trunc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  // Requester model: n_beats total to send, blen beats per burst (0 = never last).
  int n_beats [NR];
  int blen    [NR];
  int sent    [NR];
  int wseq    [NR];

  logic          full_pat [HN];
  logic [NR-1:0] g_h [HN];
  logic          w_h [HN];
  logic          t_h [HN];
  logic          b_h [HN];
  logic [NR-1:0] r_h [HN];
  logic [NR-1:0] e_g [HN];
  logic          e_w [HN];
  logic          e_t [HN];

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int i, input int s);
    return {32'(i), 32'(s), 32'h5A5A0000 + 32'(i), ~32'(s)};
  endfunction

  // Every FIFO write must be the next beat of the requester encoded in it.
  always @(negedge clk) begin : wr_mon
    int mi;
    if (rst === 1'b1 && fifo_wr_en === 1'b1) begin
      mi = int'(fifo_wr_data[127:96]);
      if (mi < 0 || mi >= NR) mi = 0;
      check_eq("wr_data", fifo_wr_data, beat(mi, wseq[mi]));
      wseq[mi]++;
      n_writes++;
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (sent[i] < n_beats[i]);
      req_last[i]  = (blen[i] > 0) && ((sent[i] % blen[i]) == blen[i] - 1);
      req_data[i*DW +: DW] = beat(i, sent[i]);
    end
  endtask

  // Called at posedge+1; each cycle drives, samples at +3, then advances.
  task automatic run(input int n);
    logic [NR-1:0] acc;
    for (int c = 0; c < n; c++) begin
      fifo_full = full_pat[c];
      drive();
      #2;
      g_h[c] = grant;
      w_h[c] = fifo_wr_en;
      t_h[c] = burst_trunc;
      b_h[c] = busy;
      r_h[c] = req_ready;
      acc    = req_valid & req_ready;
      check_eq("wen_while_full", DW'(fifo_wr_en & fifo_full), '0);
      check_eq("grant_onehot0", DW'($onehot0(grant)), DW'(1));
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) sent[i]++;
    end
    fifo_full = 1'b0;
  endtask

  task automatic clear_exp();
    for (int c = 0; c < HN; c++) begin
      e_g[c] = '0;
      e_w[c] = 1'b0;
      e_t[c] = 1'b0;
      full_pat[c] = 1'b0;
    end
  endtask

  task automatic set_exp(input int c0, input int c1, input logic [NR-1:0] g, input logic w);
    for (int c = c0; c <= c1; c++) begin
      e_g[c] = g;
      e_w[c] = w;
    end
  endtask

  task automatic cmp_hist(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      check_eq($sformatf("%s_grant_c%0d", name, c), DW'(g_h[c]), DW'(e_g[c]));
      check_eq($sformatf("%s_wren_c%0d", name, c), DW'(w_h[c]), DW'(e_w[c]));
      check_eq($sformatf("%s_busy_c%0d", name, c), DW'(b_h[c]), DW'(e_g[c] != '0));
      check_eq($sformatf("%s_trunc_c%0d", name, c), DW'(t_h[c]), DW'(e_t[c]));
    end
  endtask

  task automatic reset_dut();
    rst       = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      n_beats[i] = 0;
      blen[i]    = 1;
      sent[i]    = 0;
      wseq[i]    = 0;
    end
    n_writes = 0;
    clear_exp();
    #1;
    check_eq("rst_grant", DW'(grant), '0);
    check_eq("rst_busy", DW'(busy), '0);
    check_eq("rst_wren", DW'(fifo_wr_en), '0);
    check_eq("rst_ready", DW'(req_ready), '0);
    check_eq("rst_trunc", DW'(burst_trunc), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Single requester 1, 4-beat burst, then pointer-at-2 probe.
    reset_dut();
    n_beats[1] = 4; blen[1] = 4;
    set_exp(1, 4, 4'b0010, 1'b1);
    run(7);
    cmp_hist("t1", 7);
    check_eq("t1_beats", DW'(wseq[1]), DW'(4));
    // Req 1 and 2 valid: pointer 2 must pick 2 before 1.
    n_beats[1] = 5; blen[1] = 1;
    n_beats[2] = 1; blen[2] = 1;
    clear_exp();
    set_exp(1, 1, 4'b0100, 1'b1);
    set_exp(3, 3, 4'b0010, 1'b1);
    run(5);
    cmp_hist("t1p", 5);

    // Fairness: all four valid, 2-beat bursts, two rounds.
    reset_dut();
    for (int i = 0; i < NR; i++) begin
      n_beats[i] = 4; blen[i] = 2;
    end
    for (int b = 0; b < 8; b++) set_exp(3*b + 1, 3*b + 2, 4'(1 << (b % 4)), 1'b1);
    run(26);
    cmp_hist("t2", 26);
    check_eq("t2_writes", DW'(n_writes), DW'(16));
    for (int i = 0; i < NR; i++) check_eq($sformatf("t2_beats_r%0d", i), DW'(wseq[i]), DW'(4));

    // FIFO full for 3 cycles mid-burst of requester 0.
    reset_dut();
    n_beats[0] = 5; blen[0] = 5;
    set_exp(1, 2, 4'b0001, 1'b1);
    set_exp(3, 5, 4'b0001, 1'b0);
    set_exp(6, 8, 4'b0001, 1'b1);
    full_pat[3] = 1'b1; full_pat[4] = 1'b1; full_pat[5] = 1'b1;
    run(10);
    cmp_hist("t3", 10);
    for (int c = 3; c <= 5; c++) check_eq($sformatf("t3_ready_c%0d", c), DW'(r_h[c]), '0);
    check_eq("t3_ready_c6", DW'(r_h[6]), DW'(4'b0001));
    check_eq("t3_beats", DW'(wseq[0]), DW'(5));

    // Reset on beat 2 of a 5-beat burst from requester 2 (pointer was 2).
    reset_dut();
    n_beats[1] = 1; blen[1] = 1;
    n_beats[2] = 5; blen[2] = 5;
    set_exp(1, 1, 4'b0010, 1'b1);
    set_exp(3, 4, 4'b0100, 1'b1);
    run(5);
    cmp_hist("t4a", 5);
    drive();
    #2;
    check_eq("t4_pre_wren", DW'(fifo_wr_en), DW'(1));
    rst = 1'b0;
    #1;
    check_eq("t4_async_grant", DW'(grant), '0);
    check_eq("t4_async_busy", DW'(busy), '0);
    check_eq("t4_async_wren", DW'(fifo_wr_en), '0);
    check_eq("t4_async_ready", DW'(req_ready), '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_beats[0] = 1; blen[0] = 1;
    clear_exp();
    set_exp(1, 1, 4'b0001, 1'b1);
    set_exp(3, 5, 4'b0100, 1'b1);
    run(7);
    cmp_hist("t4b", 7);
    check_eq("t4_beats_r2", DW'(wseq[2]), DW'(5));
    check_eq("t4_beats_r0", DW'(wseq[0]), DW'(1));

    // Requester 2 streams 20 beats with no last; requester 3 waiting.
    reset_dut();
    n_beats[2] = 20; blen[2] = 0;
    n_beats[3] = 1;  blen[3] = 1;
`ifdef FIFO_ARB_BURST_LIMIT_EN
    set_exp(1, 16, 4'b0100, 1'b1);
    e_t[16] = 1'b1;
    set_exp(18, 18, 4'b1000, 1'b1);
    set_exp(20, 23, 4'b0100, 1'b1);
    set_exp(24, 25, 4'b0100, 1'b0);
    run(26);
    cmp_hist("t5", 26);
    check_eq("t5_beats_r3", DW'(wseq[3]), DW'(1));
`else
    set_exp(1, 20, 4'b0100, 1'b1);
    set_exp(21, 24, 4'b0100, 1'b0);
    run(25);
    cmp_hist("t5", 25);
    check_eq("t5_beats_r3", DW'(wseq[3]), DW'(0));
`endif
    check_eq("t5_beats_r2", DW'(wseq[2]), DW'(20));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
